// File: rtl/master1_bus_tx_16.sv
// Master-1 bus transmit stage: fetches one word from the 16-bit register bank,
// arbitrates for the shared bus and drives it to a slave until ack or timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; latches src_sel/dest_addr when it comes
// S_FETCH   | rb_read asserted; bank registers rb_rd_data at cycle end
// S_CAPTURE | bank data valid; captured into data_q at cycle end
// S_REQ     | bus_req asserted, waiting for bus_grant (no grant timeout)
// S_XFER    | bus_valid asserted, waiting up to TIMEOUT cycles for slave_ack
// S_DONE    | one-cycle done pulse
// S_ERR     | one-cycle timeout_err pulse
module master1_bus_tx_16 #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  src_sel,
    input  logic [1:0]  dest_addr,
    input  logic [15:0] rb_rd_data,
    input  logic        bus_grant,
    input  logic        slave_ack,
    output logic [1:0]  rb_sel,
    output logic        rb_read,
    output logic        bus_req,
    output logic        bus_valid,
    output logic [1:0]  bus_addr,
    output logic [15:0] bus_data,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Counter holds the number of XFER cycles already completed, so the
    // TIMEOUT-th cycle is the one that starts with TIMEOUT-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_REQ,
        S_XFER,
        S_DONE,
        S_ERR
    } state_t;

    state_t         state, state_nxt;
    logic [1:0]     sel_q, addr_q;
    logic [15:0]    data_q;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= 2'd0;
            addr_q <= 2'd0;
            data_q <= 16'd0;
            cnt    <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                sel_q  <= src_sel;
                addr_q <= dest_addr;
            end
            if (state == S_CAPTURE) begin
                data_q <= rb_rd_data;
            end
            if (state == S_REQ && bus_grant) begin
                cnt <= '0;
            end else if (state == S_XFER) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        rb_read     = 1'b0;
        bus_req     = 1'b0;
        bus_valid   = 1'b0;
        done        = 1'b0;
        timeout_err = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                rb_read   = 1'b1;
                state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_nxt = S_REQ;
            end
            S_REQ: begin
                bus_req = 1'b1;
                if (bus_grant) state_nxt = S_XFER;
            end
            S_XFER: begin
                bus_req   = 1'b1;
                bus_valid = 1'b1;
                // Ack takes priority over a timeout landing in the same cycle.
                if (slave_ack) begin
                    state_nxt = S_DONE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                timeout_err = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign rb_sel   = sel_q;
    assign bus_addr = addr_q;
    assign bus_data = data_q;

endmodule

// File: tb/tb_master1_bus_tx_16.sv
// Bench for master1_bus_tx_16: directed and randomized transfers checked
// cycle by cycle against a timeline computed from grant/ack delays.
module tb_master1_bus_tx_16;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  src_sel = 2'd0;
    logic [1:0]  dest_addr = 2'd0;
    logic [15:0] rb_rd_data = 16'd0;
    logic        bus_grant = 1'b0;
    logic        slave_ack = 1'b0;
    logic [1:0]  rb_sel;
    logic        rb_read;
    logic        bus_req;
    logic        bus_valid;
    logic [1:0]  bus_addr;
    logic [15:0] bus_data;
    logic        busy;
    logic        done;
    logic        timeout_err;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] bank [4];

    master1_bus_tx_16 #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src_sel     (src_sel),
        .dest_addr   (dest_addr),
        .rb_rd_data  (rb_rd_data),
        .bus_grant   (bus_grant),
        .slave_ack   (slave_ack),
        .rb_sel      (rb_sel),
        .rb_read     (rb_read),
        .bus_req     (bus_req),
        .bus_valid   (bus_valid),
        .bus_addr    (bus_addr),
        .bus_data    (bus_data),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Register bank model: output registered on the edge where rb_read=1.
    always @(posedge clk) begin
        if (rb_read) rb_rd_data <= bank[rb_sel];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ctrl();
        return {10'd0, rb_read, bus_req, bus_valid, busy, done, timeout_err};
    endfunction

    // g: REQ cycles without grant; a: XFER cycle index carrying ack (>TO = never).
    // noise: randomize every don't-care input; ign_c: cycle carrying a stray start.
    task automatic run_txn(input logic [1:0] sel, input logic [1:0] addr, input int g,
                           input int a, input bit noise, input int ign_c, input int gap);
        bit          acked;
        int          len;
        int          t_end;
        logic [15:0] word;
        logic [5:0]  exp;
        acked = (a <= TO);
        len   = acked ? a : TO;
        t_end = 4 + g + len;
        word  = bank[sel];
        for (int c = 0; c <= t_end; c++) begin
            if (c == 0) begin
                start     = 1'b1;
                src_sel   = sel;
                dest_addr = addr;
            end else begin
                start     = noise ? 1'($urandom) : (c == ign_c);
                src_sel   = (c == ign_c) ? 2'd3 : 2'($urandom);
                dest_addr = 2'($urandom);
            end
            if (c == 3 + g)                 bus_grant = 1'b1;
            else if (c >= 3 && c < 3 + g)   bus_grant = 1'b0;
            else                            bus_grant = noise ? 1'($urandom) : 1'b1;
            if (c == 3 + g + a)                   slave_ack = 1'b1;
            else if (c >= 4 + g && c < 3 + g + a) slave_ack = 1'b0;
            else                                  slave_ack = noise ? 1'($urandom) : 1'b1;
            @(negedge clk);
            if (c == 0) begin
                chk($sformatf("idle_ctrl c%0d", c), ctrl(), 16'd0);
            end else begin
                exp = {c == 1, c >= 3 && c < t_end, c >= 4 + g && c < t_end, 1'b1,
                       acked && c == t_end, !acked && c == t_end};
                chk($sformatf("ctrl c%0d g%0d a%0d", c, g, a), ctrl(), {10'd0, exp});
                chk($sformatf("rb_sel c%0d", c), {14'd0, rb_sel}, {14'd0, sel});
                chk($sformatf("bus_addr c%0d", c), {14'd0, bus_addr}, {14'd0, addr});
                if (c >= 3) chk($sformatf("bus_data c%0d", c), bus_data, word);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        for (int i = 0; i <= gap; i++) begin
            @(negedge clk);
            chk($sformatf("post_idle_ctrl i%0d", i), ctrl(), 16'd0);
            chk("post_idle_data", bus_data, word);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, ctrl(), 16'd0);
        chk({tag, "_sel_addr"}, {12'd0, rb_sel, bus_addr}, 16'd0);
        chk({tag, "_data"}, bus_data, 16'd0);
    endtask

    initial begin
        bank[0] = 16'h1A5A;
        bank[1] = 16'h200B;
        bank[2] = 16'h300C;
        bank[3] = 16'h4C3D;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("por");
        rst_n = 1'b1;

        run_txn(2'd1, 2'd2, 0, 1,  1'b0, -1, 0);
        run_txn(2'd1, 2'd2, 3, 1,  1'b0, -1, 0);
        run_txn(2'd0, 2'd1, 0, 99, 1'b0, -1, 1);
        run_txn(2'd3, 2'd0, 1, TO, 1'b0, -1, 0);
        run_txn(2'd1, 2'd1, 0, 2,  1'b0, 3,  2);
        run_txn(2'd2, 2'd3, 0, 1,  1'b0, -1, 0);

        // Asynchronous reset in the second XFER cycle.
        start = 1'b1; src_sel = 2'd1; dest_addr = 2'd3; bus_grant = 1'b1; slave_ack = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("rst_pre_valid", {15'd0, bus_valid}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_release");
        @(posedge clk);
        #1;

        for (int n = 0; n < 40; n++) begin
            bank[0] = 16'($urandom);
            bank[3] = 16'($urandom);
            run_txn(2'($urandom), 2'($urandom), int'($urandom_range(0, 4)),
                    int'($urandom_range(1, TO + 2)), 1'b1, -1, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/master1_bus_tx_16.md
# master1_bus_tx_16

Master-1 bus transmit stage, directly downstream of master A's 16-bit register bank. On a start command it reads one register through the bank's select/read port, holds the word, arbitrates for the shared bus, and drives the word to a slave address until the slave acknowledges or a timeout expires. It is a single-transaction engine: one transfer in flight, with no queueing.

## Interface
- TIMEOUT, 15: maximum number of XFER cycles to wait for slave_ack (legal 1–255)
- clk  in  1  system clock, all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  transfer request; sampled only in IDLE
- src_sel  in  2  source register index (R0–R3), latched with start
- dest_addr  in  2  slave address, latched with start
- rb_rd_data  in  16  register-bank read data (bank registers its output on the clock edge where rb_read=1)
- bus_grant  in  1  arbiter grant
- slave_ack  in  1  slave accepted bus_data
- rb_sel  out  2  register-bank read select
- rb_read  out  1  register-bank read enable
- bus_req  out  1  bus request to arbiter
- bus_valid  out  1  bus_data/bus_addr are valid
- bus_addr  out  2  target slave address
- bus_data  out  16  write data to slave
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on a successful transfer
- timeout_err  out  1  one-cycle pulse on an ack timeout

## Operation
- The FSM has six states: IDLE, FETCH, CAPTURE, REQ, XFER, and a terminal state that is DONE or ERR.
- IDLE: if start=1 at posedge, latch src_sel→sel_q and dest_addr→addr_q, then go to FETCH. Otherwise stay in IDLE.
- FETCH, one cycle: rb_read=1 and rb_sel=sel_q. The bank updates rb_rd_data at the end of this cycle. Next state is CAPTURE.
- CAPTURE, one cycle: rb_read=0. Latch rb_rd_data into data_q at the end of the cycle. Next state is REQ.
- REQ: bus_req=1. If bus_grant=1 at posedge, go to XFER and clear the timeout counter. Otherwise stay in REQ; there is no grant timeout.
- XFER:
  - bus_req=1, bus_valid=1, bus_addr=addr_q, bus_data=data_q.
  - The counter increments every XFER cycle.
  - If slave_ack=1 at posedge, go to DONE.
  - Else if the counter reaches TIMEOUT (the last XFER cycle), go to ERR.
  - bus_grant is ignored in XFER.
- DONE: done=1 for one cycle, bus_req=0, then go to IDLE.
- ERR: timeout_err=1 for one cycle, bus_req=0, then go to IDLE.
- rb_sel drives sel_q at all times. bus_addr and bus_data drive addr_q and data_q at all times. Only bus_valid qualifies them.
- Counter width is enough to hold TIMEOUT; it never wraps, because the state exits at TIMEOUT.
- Boundary rules:
  - start outside IDLE is ignored; no latching, no queueing.
  - start asserted in the DONE/ERR cycle is ignored. Back-to-back transfers need start in IDLE.
  - slave_ack and timeout in the same cycle: ack wins and the FSM goes to DONE.
  - slave_ack outside XFER is ignored.
  - rst_n low at any time, including mid-XFER: immediately return to IDLE, with all outputs and registers cleared.

## Timing
- Reset values: state=IDLE, and every output is 0 (rb_sel, rb_read, bus_req, bus_valid, bus_addr, bus_data, busy, done, timeout_err). sel_q, addr_q, data_q and the counter are also 0.
- Cycle numbering: edge 0 samples start, and cycle n follows edge n-1.
  - FETCH is cycle 1, CAPTURE is cycle 2, REQ is cycle 3.
  - With grant at edge 3, XFER (first bus_valid) is cycle 4.
  - With ack at edge 4, done pulses in cycle 5 and busy is low in cycle 6.
- Minimum start-to-done latency is 5 cycles. Each extra grant-wait or ack-wait cycle adds 1.
- Timeout: bus_valid is high for exactly TIMEOUT cycles, then timeout_err pulses in the next cycle.
- All outputs are registered or decoded from state. There is no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert rst_n=0 mid-XFER. Required: all outputs go to 0 asynchronously; state is IDLE after release; busy=0.
- **Basic transfer:** start with src_sel=1, dest_addr=2, bank R1=16'h200B, grant and ack held high. Required: rb_read high in cycle 1 only; bus_valid in cycle 4 with bus_data=16'h200B and bus_addr=2; done in cycle 5.
- **Grant wait:** grant delayed 3 cycles. Required: bus_req high from cycle 3, bus_valid first in cycle 7, bus_data unchanged.
- **Timeout:** TIMEOUT=4, no ack. Required: bus_valid for exactly 4 cycles, then a one-cycle timeout_err; done never asserts; bus_req drops.
- **Ack at limit:** ack arrives in the TIMEOUT-th XFER cycle. Required: done=1 and timeout_err=0.
- **Ignored start:** pulse start in REQ with src_sel=3. Required: the transfer in flight is unaffected and no second transfer occurs. Then a start in IDLE with src_sel=2 transfers 16'h300C.
